// File: rtl/axi_lite_fifo_mem_pkg.sv
`default_nettype none
//==============================================================================
// Module   : axi_lite_fifo_mem_pkg
// Brief    : Shared constants, register map and FSM state types for the
//            AXI4-Lite FIFO memory.
// Revision : 1.0 - initial release
//==============================================================================
package axi_lite_fifo_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;

   localparam int STATUS_COUNT_LSB = 16;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_GOT_AW = 2'd1,
      W_GOT_W  = 2'd2,
      W_RESP   = 2'd3
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Write response for a register select; full only matters for DATA pushes.
   function automatic logic [1:0] wr_resp(input logic [1:0] sel, input logic full);
      logic [1:0] resp;
      resp = RESP_OKAY;
      case (sel)
         REG_DATA:    resp = full ? RESP_SLVERR : RESP_OKAY;
         REG_STATUS:  resp = RESP_OKAY;
         REG_CONTROL: resp = RESP_OKAY;
         default:     resp = RESP_DECERR;
      endcase
      return resp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_fifo_mem_if.sv
`default_nettype none
//==============================================================================
// Module   : axi_lite_fifo_mem_if
// Brief    : AXI4-Lite bus bundle with master and slave views.
// Revision : 1.0 - initial release
//==============================================================================
interface axi_lite_fifo_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface
`default_nettype wire

// File: rtl/axi_lite_fifo_mem_core.sv
`default_nettype none
//==============================================================================
// Module   : sync_fifo_core
// Brief    : Single-clock FIFO; full/empty decisions use pre-edge state and
//            flush takes priority over a concurrent push.
// Revision : 1.0 - initial release
//==============================================================================
module sync_fifo_core #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 2048,
   parameter int AFULL_LEVEL  = DEPTH - 4,
   parameter int CLEAR_ON_POP = 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_push,
   input  wire logic                  i_pop,
   input  wire logic                  i_flush,
   input  wire logic [DATA_WIDTH-1:0] i_wdata,
   output logic      [DATA_WIDTH-1:0] o_rdata,
   output logic      [CNT_W-1:0]      o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_afull
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_afull   = (r_count >= CNT_W'(AFULL_LEVEL));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full & ~i_flush;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Push and clear target different slots whenever both are accepted.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
      if (w_pop_ok && (CLEAR_ON_POP != 0)) begin
         r_mem[r_rd_ptr] <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_lite_fifo_mem.sv
`default_nettype none
//==============================================================================
// Module   : axi_lite_fifo_mem
// Brief    : AXI4-Lite slave exposing a FIFO through DATA/STATUS/CONTROL
//            registers with independent read and write channels.
// Revision : 1.0 - initial release
//==============================================================================
module axi_lite_fifo_mem
   import axi_lite_fifo_mem_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 2048,
   parameter int AFULL_LEVEL  = DEPTH - 4,
   parameter int CLEAR_ON_POP = 1
) (
   input  wire logic           aclk,
   input  wire logic           areset,
   axi_lite_fifo_mem_if.slave  s_axi
);

   localparam int c_CNT_W  = $clog2(DEPTH) + 1;
   localparam int c_STRB_W = DATA_WIDTH / 8;

   wr_state_t               r_wr_state;
   rd_state_t               r_rd_state;
   logic                    r_awready;
   logic                    r_wready;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;
   logic [1:0]              r_aw_sel;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [c_STRB_W-1:0]     r_wstrb;
   logic                    r_arready;
   logic                    r_rvalid;
   logic [1:0]              r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;

   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic                    w_wr_exec;
   logic [1:0]              w_wr_sel;
   logic [DATA_WIDTH-1:0]   w_wr_data;
   logic [c_STRB_W-1:0]     w_wr_strb;
   logic [DATA_WIDTH-1:0]   w_wmask;
   logic [1:0]              w_wr_resp;
   logic [1:0]              w_ar_sel;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_flush;
   logic [DATA_WIDTH-1:0]   w_fifo_rdata;
   logic [c_CNT_W-1:0]      w_count;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_afull;
   logic [DATA_WIDTH-1:0]   w_status;
   logic [DATA_WIDTH-1:0]   w_rd_data;
   logic [1:0]              w_rd_resp;
   logic                    w_unused;

   assign w_aw_hs  = s_axi.awvalid & r_awready;
   assign w_w_hs   = s_axi.wvalid & r_wready;
   assign w_ar_hs  = s_axi.arvalid & r_arready;
   assign w_ar_sel = s_axi.araddr[3:2];

   assign w_unused = ^{s_axi.awaddr[ADDR_WIDTH-1:4], s_axi.awaddr[1:0],
                       s_axi.araddr[ADDR_WIDTH-1:4], s_axi.araddr[1:0]};

   // Address, data and strobe come from the bus or from whichever half was latched earlier.
   always_comb begin
      w_wr_exec = 1'b0;
      w_wr_sel  = r_aw_sel;
      w_wr_data = r_wdata;
      w_wr_strb = r_wstrb;
      case (r_wr_state)
         W_IDLE: begin
            w_wr_exec = w_aw_hs & w_w_hs;
            w_wr_sel  = s_axi.awaddr[3:2];
            w_wr_data = s_axi.wdata;
            w_wr_strb = s_axi.wstrb;
         end
         W_GOT_AW: begin
            w_wr_exec = w_w_hs;
            w_wr_data = s_axi.wdata;
            w_wr_strb = s_axi.wstrb;
         end
         W_GOT_W: begin
            w_wr_exec = w_aw_hs;
            w_wr_sel  = s_axi.awaddr[3:2];
         end
         default: w_wr_exec = 1'b0;
      endcase
   end

   for (genvar gi = 0; gi < c_STRB_W; gi++) begin : g_strb
      assign w_wmask[gi*8 +: 8] = {8{w_wr_strb[gi]}};
   end

   assign w_push    = w_wr_exec & (w_wr_sel == REG_DATA);
   assign w_flush   = w_wr_exec & (w_wr_sel == REG_CONTROL) & w_wr_data[0];
   assign w_pop     = w_ar_hs & (w_ar_sel == REG_DATA);
   assign w_wr_resp = wr_resp(w_wr_sel, w_full);

   sync_fifo_core #(
      .DATA_WIDTH   (DATA_WIDTH),
      .DEPTH        (DEPTH),
      .AFULL_LEVEL  (AFULL_LEVEL),
      .CLEAR_ON_POP (CLEAR_ON_POP)
   ) u_fifo (
      .clk     (aclk),
      .rst     (areset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (w_wr_data & w_wmask),
      .o_rdata (w_fifo_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_afull (w_afull)
   );

   always_comb begin
      w_status                               = '0;
      w_status[0]                            = w_empty;
      w_status[1]                            = w_full;
      w_status[2]                            = w_afull;
      w_status[STATUS_COUNT_LSB +: c_CNT_W]  = w_count;
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      case (w_ar_sel)
         REG_DATA: begin
            if (w_empty) begin
               w_rd_resp = RESP_SLVERR;
            end else begin
               w_rd_data = w_fifo_rdata;
            end
         end
         REG_STATUS:  w_rd_data = w_status;
         REG_CONTROL: w_rd_data = '0;
         default:     w_rd_resp = RESP_DECERR;
      endcase
   end

   // Readies come up one cycle after reset release so nothing is accepted during reset.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wr_state <= W_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_aw_sel   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               if (w_wr_exec) begin
                  r_wr_state <= W_RESP;
                  r_awready  <= 1'b0;
                  r_wready   <= 1'b0;
                  r_bvalid   <= 1'b1;
                  r_bresp    <= w_wr_resp;
               end else if (w_aw_hs) begin
                  r_wr_state <= W_GOT_AW;
                  r_aw_sel   <= s_axi.awaddr[3:2];
                  r_awready  <= 1'b0;
               end else if (w_w_hs) begin
                  r_wr_state <= W_GOT_W;
                  r_wdata    <= s_axi.wdata;
                  r_wstrb    <= s_axi.wstrb;
                  r_wready   <= 1'b0;
               end else begin
                  r_awready  <= 1'b1;
                  r_wready   <= 1'b1;
               end
            end
            W_GOT_AW: begin
               if (w_wr_exec) begin
                  r_wr_state <= W_RESP;
                  r_wready   <= 1'b0;
                  r_bvalid   <= 1'b1;
                  r_bresp    <= w_wr_resp;
               end
            end
            W_GOT_W: begin
               if (w_wr_exec) begin
                  r_wr_state <= W_RESP;
                  r_awready  <= 1'b0;
                  r_bvalid   <= 1'b1;
                  r_bresp    <= w_wr_resp;
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  r_wr_state <= W_IDLE;
                  r_bvalid   <= 1'b0;
                  r_awready  <= 1'b1;
                  r_wready   <= 1'b1;
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rd_state <= R_DATA;
                  r_arready  <= 1'b0;
                  r_rvalid   <= 1'b1;
                  r_rdata    <= w_rd_data;
                  r_rresp    <= w_rd_resp;
               end else begin
                  r_arready  <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  r_rd_state <= R_IDLE;
                  r_rvalid   <= 1'b0;
                  r_arready  <= 1'b1;
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rresp   = r_rresp;
   assign s_axi.rdata   = r_rdata;

endmodule
`default_nettype wire

// File: doc/axi_lite_fifo_mem.md
Name: axi_lite_fifo_mem

Overview:
- Parametrised AXI4-Lite slave fronting a synchronous FIFO; successor to the fixed-size 8 KB instruction FIFO memory.
- Writes to the DATA register push; reads from it pop. Adds STATUS/CONTROL registers, error responses and independent read/write channels, so push and pop can occur in the same cycle.
- Sits between the AXI-Lite interconnect and a core-side instruction/data stream loader.

Parameters:
- DATA_WIDTH, 32: AXI data width and FIFO word width; must be 32 or 64.
- ADDR_WIDTH, 32: AXI address width.
- DEPTH, 2048: FIFO entries; power of two, at least 4.
- AFULL_LEVEL, DEPTH-4: count at or above which STATUS.afull=1.
- CLEAR_ON_POP, 1: 1 = popped slot written to 0; 0 = slot left untouched.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write-address valid
- awready  out  1  write-address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  write-data valid
- wready  out  1  write-data ready
- bresp  out  2  write response
- bvalid  out  1  write-response valid
- bready  in  1  write-response ready
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read-address valid
- arready  out  1  read-address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read-data valid
- rready  in  1  read-data ready

Behaviour:
- Register map, decoded on addr[3:2]; addr[1:0] and bits above 3 are ignored:
  - 0 DATA: write pushes, read pops.
  - 1 STATUS (read-only): bit0 empty, bit1 full, bit2 afull, bits[16+:$clog2(DEPTH)+1] count.
  - 2 CONTROL: write bit0=1 flushes; reads return 0.
  - 3 reserved: DECERR on read and write.
- Reset: while areset=1, every ready/valid output is 0, bresp/rresp/rdata are 0, pointers and count are 0, and both FSMs are in IDLE. The storage array is not reset.
- Reset mid-transaction aborts it; no response is issued afterwards.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - W_IDLE: awready=wready=1. AW and W accepted in the same cycle go to W_RESP. AW only goes to W_GOT_AW and latches the address. W only goes to W_GOT_W and latches data/strobe.
  - W_GOT_AW: wready=1 only. W_GOT_W: awready=1 only.
  - The execute happens on the edge of the completing handshake; bvalid=1 in the next cycle and is held until bready, then the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake edge the target is read, rdata/rresp are registered, and any pop happens; state goes to R_DATA.
  - R_DATA: rvalid=1 with rdata/rresp held stable until rready, then R_IDLE. Read latency is 1 cycle after AR.
- Push:
  - If not full, mem[wr_ptr] gets wdata with bytes where wstrb=0 forced to 0; wr_ptr increments (wraps at DEPTH); bresp=OKAY.
  - If full, data is dropped, no state changes, and bresp=SLVERR.
- Pop:
  - If not empty, rdata=mem[rd_ptr]; rd_ptr increments (wraps); slot is zeroed if CLEAR_ON_POP; rresp=OKAY.
  - If empty, rdata=0, rresp=SLVERR, no state changes.
- Full/empty are evaluated from pre-edge state:
  - A push while full is rejected even if a pop happens in the same cycle.
  - A pop while empty is rejected even if a push happens in the same cycle.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Count is $clog2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0). Pointers are $clog2(DEPTH) bits with natural wrap.
- Flush: pointers and count go to 0 on the execute edge; bresp=OKAY.
  - A same-cycle pop still returns the pre-flush head with OKAY.
  - A same-cycle push is discarded and still returns OKAY; flush wins.
- CONTROL write with bit0=0 has no effect and returns OKAY.
- STATUS read reflects pre-edge state and returns OKAY.

Decomposition:
- axi_lite_pkg additions:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - REG_DATA=2'd0, REG_STATUS=2'd1, REG_CONTROL=2'd2.
  - STATUS_COUNT_LSB=16.
  - state enums for the write and read FSMs.
- Sub-module sync_fifo_core:
  - Parametrised by DATA_WIDTH, DEPTH, CLEAR_ON_POP.
  - Inputs: push, pop, flush, wdata. Outputs: rdata, count, full, empty, afull.
  - The AXI wrapper holds both FSMs and the address decode.

Test Plan:
- Reset, then write DATA 0xA5A5_0001..0xA5A5_0004 and read DATA x4 -> same order, all OKAY; final STATUS = 0x0000_0001 (empty, count 0).
- DEPTH=4, 5 pushes -> 5th bresp=SLVERR. STATUS count=4, full=1, afull=1. Pop x4 returns the first 4 values.
- Read DATA when empty -> rdata=0, rresp=SLVERR. Read offset 0xC -> DECERR.
- W presented 3 cycles before AW (wdata 0x1234_5678, wstrb=4'b0011) -> single push of 0x0000_5678. bvalid rises one cycle after the AW handshake; bready low for 5 cycles keeps bvalid and bresp stable.
- FIFO holding 2 entries, push and pop on the same edge -> count stays 2 and the pop returns the oldest entry. Then CONTROL=1 concurrent with a pop -> pop OKAY with old head; STATUS afterwards = empty.
- Assert areset during R_DATA with rready low -> rvalid drops immediately (asynchronously). After release STATUS reads empty, count 0.
